// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - byte-serial sequencer driving an external 8-bit ALU for wide ADD/AND/OR
// One ALU byte per EXEC cycle, LSB first; flags are finalised on the last byte.

`ifndef ADD_FN
`define ADD_FN 2'b00
`endif
`ifndef AND_FN
`define AND_FN 2'b01
`endif
`ifndef OR_FN
`define OR_FN 2'b10
`endif

module alu_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [8*NBYTES-1:0]   result,
  output logic [2:0]            CZN,
  output logic [7:0]            alu_in1,
  output logic [7:0]            alu_in2,
  output logic                  c_in,
  output logic [1:0]            opcode,
  input  logic [7:0]            alu_out,
  input  logic [2:0]            CZN_from_ALU
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [1:0]      op_q;
  logic [W-1:0]    a_q, b_q;
  logic            cin_q;
  logic            carry_q;
  logic            zacc_q;
  logic [W-1:0]    result_q;
  logic [2:0]      czn_q;
  logic            err_q;

  logic            legal_op;
  logic            last_byte;
  logic            zacc_next;
  logic [IW+2:0]   byte_lsb;
  logic            unused_alu_flags;

  assign legal_op  = (op == `ADD_FN) || (op == `AND_FN) || (op == `OR_FN);
  assign last_byte = (idx_q == IW'(NBYTES - 1));
  assign zacc_next = zacc_q & (alu_out == 8'h00);
  assign byte_lsb  = {idx_q, 3'b000};

  // The ALU's own Z and N describe a single byte only, so they are not useful here.
  assign unused_alu_flags = ^CZN_from_ALU[2:1];

  assign result = result_q;
  assign CZN    = czn_q;
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    alu_in1 = 8'h00;
    alu_in2 = 8'h00;
    c_in    = 1'b0;
    opcode  = `ADD_FN;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = legal_op ? EXEC : DONE;
        end
      end
      EXEC: begin
        busy    = 1'b1;
        alu_in1 = a_q[byte_lsb +: 8];
        alu_in2 = b_q[byte_lsb +: 8];
        opcode  = op_q;
        if (op_q == `ADD_FN) begin
          c_in = (idx_q == '0) ? cin_q : carry_q;
        end
        if (last_byte) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      op_q     <= `ADD_FN;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b1;
      result_q <= '0;
      czn_q    <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            cin_q    <= carry_in;
            idx_q    <= '0;
            zacc_q   <= 1'b1;
            result_q <= '0;
            czn_q    <= 3'b000;
            err_q    <= ~legal_op;
          end
        end
        EXEC: begin
          result_q[byte_lsb +: 8] <= alu_out;
          zacc_q                  <= zacc_next;
          carry_q                 <= CZN_from_ALU[0];
          if (last_byte) begin
            // The last byte written is the MSB byte, so its bit 7 is the wide N flag.
            czn_q <= {alu_out[7], zacc_next, (op_q == `ADD_FN) & CZN_from_ALU[0]};
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
